// File: rtl/aq_axis_if.sv
// AXI4-Stream handshake bundle between a stream source (master) and a sink (slave).
interface aq_axis_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  TVALID;
  logic                  TREADY;
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TLAST;

  modport master (output TVALID, output TDATA, output TLAST, input  TREADY);
  modport slave  (input  TVALID, input  TDATA, input  TLAST, output TREADY);
endinterface

// File: rtl/aq_axis_pattern_checker.sv
// AXIS sink checking an incrementing data pattern, with optional LFSR-driven
// TREADY back-pressure, beat/error counters and first-failure capture.
module aq_axis_pattern_checker #(
  parameter int          DATA_WIDTH = 64,
  parameter logic [63:0] SEED       = 64'hFEDCBA98_00000000,
  parameter int          CHECK_LAST = 1,
  parameter logic [7:0]  LFSR_INIT  = 8'hA5
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [31:0]           EXPECT_COUNT,
  input  logic                  STALL_EN,
  aq_axis_if.slave              S_AXIS,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [31:0]           RX_COUNT,
  output logic [31:0]           ERR_COUNT,
  output logic [31:0]           FIRST_ERR_INDEX,
  output logic [DATA_WIDTH-1:0] FIRST_ERR_DATA
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  localparam logic [DATA_WIDTH-1:0] SEED_W = DATA_WIDTH'(SEED);

  state_e                state_q, state_d;
  logic [31:0]           target_q, target_d;
  logic [31:0]           rx_q, rx_d;
  logic [31:0]           err_q, err_d;
  logic [31:0]           fei_q, fei_d;
  logic [DATA_WIDTH-1:0] fed_q, fed_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [7:0]            lfsr_q, lfsr_d;
  logic                  tready_q, tready_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;

  logic [7:0] lfsr_step;
  logic       xfer, is_last, mism;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    rx_d     = rx_q;
    err_d    = err_q;
    fei_d    = fei_q;
    fed_d    = fed_q;
    exp_d    = exp_q;
    lfsr_d   = lfsr_q;

    // Galois form of x^8+x^6+x^5+x^4+1, shifting right
    lfsr_step = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    xfer      = (state_q == RUN) && S_AXIS.TVALID && tready_q;
    is_last   = (rx_q == target_q - 32'd1);
    mism      = (S_AXIS.TDATA != exp_q) ||
                ((CHECK_LAST != 0) && (S_AXIS.TLAST != is_last));

    case (state_q)
      RUN: begin
        lfsr_d = lfsr_step;
        if (xfer) begin
          rx_d  = rx_q + 32'd1;
          exp_d = exp_q + 1'b1;
          if (mism) begin
            if (err_q != 32'hFFFF_FFFF) err_d = err_q + 32'd1;
            if (err_q == 32'd0) begin
              fei_d = rx_q;
              fed_d = S_AXIS.TDATA;
            end
          end
          if (is_last) state_d = FIN;
        end
      end
      default: begin
        if (START) begin
          target_d = EXPECT_COUNT;
          rx_d     = '0;
          err_d    = '0;
          fei_d    = '0;
          fed_d    = '0;
          exp_d    = SEED_W;
          lfsr_d   = LFSR_INIT;
          state_d  = (EXPECT_COUNT != 32'd0) ? RUN : FIN;
        end
      end
    endcase

    // Ready tracks the LFSR value that will be current next cycle
    tready_d = (state_d == RUN) && (STALL_EN ? lfsr_d[0] : 1'b1);
    done_d   = (state_d == FIN);
    pass_d   = (state_d == FIN) && (err_d == 32'd0);
  end

  always_ff @(posedge S_AXIS_ACLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      target_q <= '0;
      rx_q     <= '0;
      err_q    <= '0;
      fei_q    <= '0;
      fed_q    <= '0;
      exp_q    <= SEED_W;
      lfsr_q   <= LFSR_INIT;
      tready_q <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      rx_q     <= rx_d;
      err_q    <= err_d;
      fei_q    <= fei_d;
      fed_q    <= fed_d;
      exp_q    <= exp_d;
      lfsr_q   <= lfsr_d;
      tready_q <= tready_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign S_AXIS.TREADY   = tready_q;
  assign BUSY            = (state_q == RUN);
  assign DONE            = done_q;
  assign PASS            = pass_q;
  assign RX_COUNT        = rx_q;
  assign ERR_COUNT       = err_q;
  assign FIRST_ERR_INDEX = fei_q;
  assign FIRST_ERR_DATA  = fed_q;
endmodule
